// File: rtl/aes_core_driver_if.sv
// Host command/result channel and AES core handshake bundle for aes_core_driver.
// The slave modport is the driver's view; master is the host plus core side.
interface aes_core_driver_if;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_op;
   logic [127:0] cmd_data;
   logic         res_valid;
   logic         res_ready;
   logic [127:0] res_data;
   logic         res_err;
   logic [127:0] Kin;
   logic [127:0] Din;
   logic [127:0] Dout;
   logic         Krdy;
   logic         Drdy;
   logic         Kvld;
   logic         Dvld;
   logic         EN;
   logic         BSY;
   logic         trig;

   modport master (
      output cmd_valid, cmd_op, cmd_data, res_ready, Dout, Kvld, Dvld, BSY,
      input  cmd_ready, res_valid, res_data, res_err, Kin, Din, Krdy, Drdy, EN, trig
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, res_ready, Dout, Kvld, Dvld, BSY,
      output cmd_ready, res_valid, res_data, res_err, Kin, Din, Krdy, Drdy, EN, trig
   );
endinterface

// File: rtl/aes_core_driver.sv
// Host-side initiator for a 128-bit AES core: sequences key load and encrypt
// handshakes, captures the ciphertext and drives a scope trigger around the encryption.
module aes_core_driver #(
   parameter int TIMEOUT   = 4096,
   parameter int TRIG_HOLD = 8
) (
   input logic              i_clk,
   input logic              i_rst,
   aes_core_driver_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + 1) + 1;
   localparam int HW = $clog2(TRIG_HOLD + 1) + 1;
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TO_MAX    = CW'(TIMEOUT);
   localparam logic [HW-1:0] HOLD_INIT = HW'(TRIG_HOLD);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KREQ  = 3'd1,
      ST_KWAIT = 3'd2,
      ST_DREQ  = 3'd3,
      ST_DWAIT = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

   state_t          r_state;
   logic            r_cmd_ready;
   logic            r_res_valid;
   logic            r_res_err;
   logic [127:0]    r_res_data;
   logic [127:0]    r_kin;
   logic [127:0]    r_din;
   logic            r_krdy;
   logic            r_drdy;
   logic            r_en;
   logic            r_trig;
   logic            r_key_loaded;
   logic [CW-1:0]   r_cnt;
   logic [HW-1:0]   r_hold;
   logic            w_to_fire;

   // Timeout fires on the last allowed wait cycle; a strobe in that cycle takes priority.
   assign w_to_fire = (TIMEOUT != 32'sd0) && (r_cnt == TO_LAST);

   assign bus.cmd_ready = r_cmd_ready;
   assign bus.res_valid = r_res_valid;
   assign bus.res_err   = r_res_err;
   assign bus.res_data  = r_res_data;
   assign bus.Kin       = r_kin;
   assign bus.Din       = r_din;
   assign bus.Krdy      = r_krdy;
   assign bus.Drdy      = r_drdy;
   assign bus.EN        = r_en;
   assign bus.trig      = r_trig;

   // Command FSM with registered handshake, result and trigger outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_cmd_ready  <= 1'b1;
         r_res_valid  <= 1'b0;
         r_res_err    <= 1'b0;
         r_res_data   <= 128'd0;
         r_kin        <= 128'd0;
         r_din        <= 128'd0;
         r_krdy       <= 1'b0;
         r_drdy       <= 1'b0;
         r_en         <= 1'b0;
         r_trig       <= 1'b0;
         r_key_loaded <= 1'b0;
         r_cnt        <= {CW{1'b0}};
         r_hold       <= {HW{1'b0}};
      end else begin
         r_en   <= 1'b1;
         r_krdy <= 1'b0;
         r_drdy <= 1'b0;
         // Post-capture trigger tail runs independently of the FSM.
         if (r_hold != {HW{1'b0}}) begin
            r_hold <= r_hold - HW'(1);
            if (r_hold == HW'(1)) begin
               r_trig <= 1'b0;
            end else begin
               r_trig <= r_trig;
            end
         end else begin
            r_hold <= r_hold;
         end
         case (r_state)
            ST_IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  if (!bus.cmd_op) begin
                     r_kin   <= bus.cmd_data;
                     r_krdy  <= 1'b1;
                     r_state <= ST_KREQ;
                  end else begin
                     r_din <= bus.cmd_data;
                     if (r_key_loaded) begin
                        r_state <= ST_DREQ;
                     end else begin
                        r_res_err   <= 1'b1;
                        r_res_data  <= 128'd0;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_RESP;
                     end
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_KREQ: begin
               r_cnt   <= {CW{1'b0}};
               r_state <= ST_KWAIT;
            end
            ST_KWAIT: begin
               if (bus.Kvld) begin
                  r_key_loaded <= 1'b1;
                  r_res_err    <= 1'b0;
                  r_res_data   <= 128'd0;
                  r_res_valid  <= 1'b1;
                  r_state      <= ST_RESP;
               end else if (w_to_fire) begin
                  r_key_loaded <= 1'b0;
                  r_res_err    <= 1'b1;
                  r_res_data   <= 128'd0;
                  r_res_valid  <= 1'b1;
                  r_state      <= ST_RESP;
               end else if (r_cnt != TO_MAX) begin
                  r_cnt <= r_cnt + CW'(1);
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            ST_DREQ: begin
               if (!bus.BSY) begin
                  r_drdy  <= 1'b1;
                  r_trig  <= 1'b1;
                  r_hold  <= {HW{1'b0}};
                  r_cnt   <= {CW{1'b0}};
                  r_state <= ST_DWAIT;
               end else begin
                  r_state <= ST_DREQ;
               end
            end
            ST_DWAIT: begin
               if (bus.Dvld) begin
                  r_res_data  <= bus.Dout;
                  r_res_err   <= 1'b0;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_RESP;
                  if (TRIG_HOLD == 32'sd0) begin
                     r_trig <= 1'b0;
                  end else begin
                     r_hold <= HOLD_INIT;
                  end
               end else if (w_to_fire) begin
                  r_res_data  <= 128'd0;
                  r_res_err   <= 1'b1;
                  r_res_valid <= 1'b1;
                  r_trig      <= 1'b0;
                  r_hold      <= {HW{1'b0}};
                  r_state     <= ST_RESP;
               end else if (r_cnt != TO_MAX) begin
                  r_cnt <= r_cnt + CW'(1);
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            ST_RESP: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  r_state <= ST_RESP;
               end
            end
            default: begin
               r_res_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
